// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo ramp sequencer.
//  POS_W        width of a servo position
//  pos_t        servo position type (0..255)
//  seq_state_t  sequencer FSM states
package servo_pkg;

  localparam int unsigned POS_W           = 8;
  localparam int unsigned FRAME_TICKS_DEF = 2560;
  localparam int unsigned BIAS_TICKS_DEF  = 64;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } seq_state_t;

endpackage

// File: rtl/servo_timebase.sv
// Shared frame timebase: prescaler producing one tick every TICK_DIV clocks and
// a frame counter stepping once per tick, wrapping at FRAME_TICKS.
//  clk, reset          clock and synchronous active-high reset
//  o_frame_cnt         current tick index within the frame
//  o_frame_start_c     combinational; high in the clk where the frame counter wraps to 0
module servo_timebase #(
  parameter int unsigned TICK_DIV    = 391,
  parameter int unsigned FRAME_TICKS = 2560
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [$clog2(FRAME_TICKS)-1:0] o_frame_cnt,
  output logic                           o_frame_start_c
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FC_W = $clog2(FRAME_TICKS);

  logic [PS_W-1:0] r_presc;
  logic [FC_W-1:0] r_frame_cnt;
  logic            w_tick;
  logic            w_wrap;

  assign w_tick          = (r_presc == PS_W'(TICK_DIV - 1));
  assign w_wrap          = (r_frame_cnt == FC_W'(FRAME_TICKS - 1));
  assign o_frame_start_c = w_tick && w_wrap;
  assign o_frame_cnt     = r_frame_cnt;

  // Prescaler and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc     <= '0;
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_presc     <= '0;
      r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + FC_W'(1);
    end else begin
      r_presc <= r_presc + PS_W'(1);
    end
  end

endmodule

// File: rtl/servo_ramp_sequencer.sv
// Multi-channel servo controller with per-frame rate-limited slewing.
//  clk, reset     clock and synchronous active-high reset
//  cmd_valid/cmd_ready/cmd_ch/cmd_pos   host target-position write (cmd_ready combinational)
//  ch_enable      per-channel pulse enable
//  pwm_out        servo pulses, high for BIAS_TICKS+cur+1 ticks at frame start
//  at_target      current position equals target position
//  frame_strobe   one-clk pulse at the start of each frame
module servo_ramp_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TICK_DIV    = 391,
  parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int unsigned BIAS_TICKS  = BIAS_TICKS_DEF,
  parameter int unsigned STEP_MAX    = 4,
  parameter int unsigned RESET_POS   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_ch,
  input  pos_t              cmd_pos,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] at_target,
  output logic              frame_strobe
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned FC_W  = $clog2(FRAME_TICKS);
  localparam int unsigned LIM_W = 10;
  localparam int unsigned CMP_W = (FC_W > LIM_W) ? FC_W : LIM_W;
  localparam int unsigned DIF_W = POS_W + 1;

  seq_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  pos_t              r_cur [NUM_CH];
  pos_t              r_tgt [NUM_CH];
  logic [NUM_CH-1:0] r_pwm, r_at;
  logic              r_strobe;

  logic [FC_W-1:0]   w_frame_cnt;
  logic              w_frame_start;
  logic              w_cmd_hit;
  pos_t              w_cur_sel, w_tgt_sel, w_slew;
  logic [DIF_W-1:0]  w_diff, w_mag;
  logic              w_step_ok;
  logic [NUM_CH-1:0] w_pwm_nxt, w_at_nxt;

  servo_timebase #(
    .TICK_DIV    (TICK_DIV),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_timebase (
    .clk             (clk),
    .reset           (reset),
    .o_frame_cnt     (w_frame_cnt),
    .o_frame_start_c (w_frame_start)
  );

  assign cmd_ready    = (r_state == ST_IDLE) && !reset;
  // Out-of-range channels complete the handshake but write nothing
  assign w_cmd_hit    = cmd_valid && cmd_ready && ({28'd0, cmd_ch} < NUM_CH);
  assign pwm_out      = r_pwm;
  assign at_target    = r_at;
  assign frame_strobe = r_strobe;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: one UPDATE clk per channel, entered on frame start
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_start) begin
          w_state_nxt = ST_UPDATE;
          w_idx_nxt   = '0;
        end
      end
      ST_UPDATE: begin
        if (r_idx == IDX_W'(NUM_CH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Slew unit for the visited channel; magnitude > STEP_MAX guarantees no wrap
  always_comb begin
    w_cur_sel = r_cur[r_idx];
    w_tgt_sel = r_tgt[r_idx];
    w_diff    = {1'b0, w_tgt_sel} - {1'b0, w_cur_sel};
    w_mag     = w_diff[DIF_W-1] ? (~w_diff + DIF_W'(1)) : w_diff;
    w_step_ok = (STEP_MAX == 0) || (w_mag <= DIF_W'(STEP_MAX));
    if (w_step_ok) begin
      w_slew = w_tgt_sel;
    end else if (w_diff[DIF_W-1]) begin
      w_slew = w_cur_sel - POS_W'(STEP_MAX);
    end else begin
      w_slew = w_cur_sel + POS_W'(STEP_MAX);
    end
  end

  // Pulse comparators and target flags
  always_comb begin
    w_pwm_nxt = '0;
    w_at_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pwm_nxt[i] = ch_enable[i] &&
                     (CMP_W'(w_frame_cnt) <= CMP_W'(LIM_W'(BIAS_TICKS) + LIM_W'(r_cur[i])));
      w_at_nxt[i]  = (r_cur[i] == r_tgt[i]);
    end
  end

  // Position storage and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cur[i] <= POS_W'(RESET_POS);
        r_tgt[i] <= POS_W'(RESET_POS);
      end
      r_pwm    <= '0;
      r_at     <= '1;
      r_strobe <= 1'b0;
    end else begin
      if (w_cmd_hit) begin
        r_tgt[cmd_ch[IDX_W-1:0]] <= cmd_pos;
      end
      if (r_state == ST_UPDATE) begin
        r_cur[r_idx] <= w_slew;
      end
      r_pwm    <= w_pwm_nxt;
      r_at     <= w_at_nxt;
      r_strobe <= w_frame_start;
    end
  end

endmodule
